hilo_unit: RTL and testbench
============================

# hilo_unit

Control and storage stage wrapped around the iterative unsigned multiplier in the ALU. It accepts HI/LO-class instructions from decode, launches the multiplier with a one-cycle load pulse, and applies sign correction for signed MULT. It writes the 64-bit result into the architectural HI/LO registers and serves MFHI/MFLO. While a multiply is in flight it stalls the pipeline through `op_ready`.

## Interface
- No parameters.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  decoded HI/LO-class instruction present this cycle.
- `op`  in  3  000 MULTU, 001 MULT, 010 MTHI, 011 MTLO, 100 MFHI, 101 MFLO; 110/111 reserved.
- `rs_data`  in  32  rs operand (multiplicand A, or MTHI/MTLO source).
- `rt_data`  in  32  rt operand (multiplicand B).
- `op_ready`  out  1  op accepted when `op_valid && op_ready`; low = stall.
- `mf_valid`  out  1  MFHI/MFLO result valid.
- `mf_data`  out  32  MFHI/MFLO result.
- `busy`  out  1  multiply in flight (state ≠ IDLE).
- `mul_validIn`  out  1  multiplier load pulse.
- `mul_SrcA`  out  32  unsigned operand A to multiplier.
- `mul_SrcB`  out  32  unsigned operand B to multiplier.
- `mul_validOut`  in  1  multiplier done; may stay high after completion.
- `mul_Hi`  in  32  upper half of the unsigned product.
- `mul_Lo`  in  32  lower half of the unsigned product.

## Operation
States are IDLE, ISSUE and WAIT.

- **Ready rule:** `op_ready = (state == IDLE)`, combinational.

**IDLE**
- MTHI: HI <= rs_data.
- MTLO: LO <= rs_data.
- MFHI / MFLO: register HI or LO into `mf_data` and pulse `mf_valid`.
- MULTU:
  - opA <= rs_data, opB <= rt_data, neg <= 0.
  - Next state ISSUE.
- MULT:
  - opA <= |rs_data|, opB <= |rt_data| (32-bit two's-complement magnitude; 0x80000000 maps to 0x80000000 unsigned).
  - neg <= rs_data[31] ^ rt_data[31].
  - Next state ISSUE.
- Reserved op: accepted, no effect.

**ISSUE** (exactly one cycle)
- `mul_validIn` = 1, `mul_SrcA` = opA, `mul_SrcB` = opB.
- `mul_validOut` is ignored: it may still reflect the previous product.
- Next state WAIT.

**WAIT**
- `mul_validIn` = 0; opA/opB held on `mul_SrcA`/`mul_SrcB`.
- On the first cycle with `mul_validOut` = 1:
  - {HI,LO} <= neg ? (~{mul_Hi,mul_Lo} + 1) : {mul_Hi,mul_Lo}, as a 64-bit negate.
  - Next state IDLE.
- Otherwise remain in WAIT; there is no timeout.

**General**
- `mul_validOut` is ignored in IDLE.
- `busy` = state ≠ IDLE.

## Timing
**Reset** (`reset_n` low, asynchronous):
- state IDLE; HI, LO, opA, opB and neg cleared.
- `mf_valid` = 0, `mf_data` = 0, `mul_validIn` = 0, `busy` = 0.
- `op_ready` = 1.

**MFHI / MFLO**
- Accepted at edge E; `mf_valid` and `mf_data` are valid in the cycle after E, for one cycle.

**MTHI / MTLO**
- Accepted at edge E; HI/LO is updated at E.
- An MFHI accepted on the next cycle returns the new value.

**MULT / MULTU**
- Accepted at edge E; ISSUE during cycle E+1 (`mul_validIn` high); WAIT from E+2.
- HI/LO is written at the edge ending the first WAIT cycle with `mul_validOut` high. IDLE, with `op_ready` = 1, follows in the next cycle.
- Total stall = 2 cycles + multiplier latency.

**Hazard**
- An MFHI/MFLO presented during a multiply stalls and is accepted in the first IDLE cycle. It returns the final, sign-corrected product.

**Boundary cases**
- Back-to-back MULTs: the second is accepted only in IDLE.
- Reset during ISSUE or WAIT: abort, clear HI/LO, return to IDLE; a late `mul_validOut` is ignored.
- A zero operand follows the same path; the multiplier may finish early.

## Test plan
- **MULTU, all-ones:** 0xFFFFFFFF × 0xFFFFFFFF, then MFHI and MFLO → `mf_data` 0xFFFFFFFE, then 0x00000001.
- **MULT, mixed sign:** 0xFFFFFFFD (−3) × 0x00000007 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; `mul_SrcA` = 0x00000003 during ISSUE.
- **MULT, most-negative operands:** 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0x00000000.
- **Stale done flag:**
  - Stimulus: multiplier model holds `mul_validOut` high from the prior op; issue MULTU 2 × 3, then MFLO on the next cycle.
  - Response: `op_ready` = 0 through WAIT, the stale flag is not captured in ISSUE, and MFLO returns 0x00000006.
- **Move-to / move-from:** MTHI 0x12345678, MTLO 0x9ABCDEF0, MFHI, MFLO on consecutive cycles → returns 0x12345678, then 0x9ABCDEF0; `op_ready` never drops.
- **Reset mid-multiply:**
  - Stimulus: `reset_n` low for one cycle during WAIT, then `mul_validOut` pulses.
  - Response: HI = LO = 0, `busy` = 0, `op_ready` = 1, and MFHI returns 0x00000000.

Source files
------------

// File: rtl/hilo_unit.sv
// HI/LO control around an iterative unsigned multiplier: MTHI/MTLO take effect immediately, MFHI/MFLO return data one cycle after accept.
// MULT/MULTU stall op_ready for 2 cycles plus the multiplier latency; signed MULT is handled as sign-magnitude with a final 64-bit negate.
module hilo_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        op_ready,
  output logic        mf_valid,
  output logic [31:0] mf_data,
  output logic        busy,
  output logic        mul_validIn,
  output logic [31:0] mul_SrcA,
  output logic [31:0] mul_SrcB,
  input  logic        mul_validOut,
  input  logic [31:0] mul_Hi,
  input  logic [31:0] mul_Lo
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MTLO  = 3'b011;
  localparam logic [2:0] OP_MFHI  = 3'b100;
  localparam logic [2:0] OP_MFLO  = 3'b101;

  state_t      state;
  logic [31:0] hi_q, lo_q, op_a, op_b;
  logic        neg;
  logic [31:0] rs_mag, rt_mag;
  logic [63:0] prod, prod_fix;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign rs_mag   = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
  assign rt_mag   = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
  assign prod     = {mul_Hi, mul_Lo};
  assign prod_fix = neg ? (~prod + 64'd1) : prod;

  assign op_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign mul_SrcA = op_a;
  assign mul_SrcB = op_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      op_a        <= '0;
      op_b        <= '0;
      neg         <= 1'b0;
      mf_valid    <= 1'b0;
      mf_data     <= '0;
      mul_validIn <= 1'b0;
    end else begin
      mf_valid    <= 1'b0;
      mul_validIn <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            case (op)
              OP_MULTU: begin
                op_a        <= rs_data;
                op_b        <= rt_data;
                neg         <= 1'b0;
                mul_validIn <= 1'b1;
                state       <= ISSUE;
              end
              OP_MULT: begin
                op_a        <= rs_mag;
                op_b        <= rt_mag;
                neg         <= rs_data[31] ^ rt_data[31];
                mul_validIn <= 1'b1;
                state       <= ISSUE;
              end
              OP_MTHI: hi_q <= rs_data;
              OP_MTLO: lo_q <= rs_data;
              OP_MFHI: begin
                mf_data  <= hi_q;
                mf_valid <= 1'b1;
              end
              OP_MFLO: begin
                mf_data  <= lo_q;
                mf_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        // done flag is not looked at here: it may still belong to the previous product
        ISSUE: state <= WAIT;
        WAIT: begin
          if (mul_validOut) begin
            {hi_q, lo_q} <= prod_fix;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a behavioural multiplier whose done flag stays high until the next load.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        op_ready, mf_valid, busy, mul_validIn;
  logic [31:0] mf_data, mul_SrcA, mul_SrcB;
  logic        mul_validOut = 1'b0;
  logic [31:0] mul_Hi = '0;
  logic [31:0] mul_Lo = '0;

  int vectors = 0;
  int miscompares = 0;

  hilo_unit dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .op_ready(op_ready),
    .mf_valid(mf_valid), .mf_data(mf_data), .busy(busy),
    .mul_validIn(mul_validIn), .mul_SrcA(mul_SrcA), .mul_SrcB(mul_SrcB),
    .mul_validOut(mul_validOut), .mul_Hi(mul_Hi), .mul_Lo(mul_Lo)
  );

  always #5 clk = ~clk;

  // Multiplier model: not reset, done flag sticky until the next load pulse
  int          lat = 4;
  int          cnt = 0;
  logic        pending = 1'b0;
  logic [63:0] prod_m = '0;

  always @(posedge clk) begin
    if (mul_validIn) begin
      mul_validOut <= 1'b0;
      prod_m       <= {32'd0, mul_SrcA} * {32'd0, mul_SrcB};
      cnt          <= lat;
      pending      <= 1'b1;
    end else if (pending) begin
      if (cnt == 0) begin
        mul_validOut <= 1'b1;
        mul_Hi       <= prod_m[63:32];
        mul_Lo       <= prod_m[31:0];
        pending      <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Present an op at a negedge, wait (bounded) for op_ready, accept on the posedge,
  // return at the following negedge, i.e. in the cycle after acceptance.
  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    op = o; rs_data = a; rt_data = b; op_valid = 1'b1;
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", {31'd0, op_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic mf(input logic [2:0] o, input string tag, input logic [31:0] exp);
    send(o, '0, '0);
    check({tag, "_vld"}, {31'd0, mf_valid}, 32'd1);
    check(tag, mf_data, exp);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, op_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mf_vld", {31'd0, mf_valid}, 32'd0);
    check("rst_mf_dat", mf_data, 32'd0);
    check("rst_load", {31'd0, mul_validIn}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // MULTU all-ones
    send(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_load", {31'd0, mul_validIn}, 32'd1);
    check("multu_busy", {31'd0, busy}, 32'd1);
    check("multu_ready", {31'd0, op_ready}, 32'd0);
    check("multu_srca", mul_SrcA, 32'hFFFFFFFF);
    mf(3'b100, "multu_hi", 32'hFFFFFFFE);
    mf(3'b101, "multu_lo", 32'h00000001);

    // MULT mixed sign: -3 * 7 = -21
    send(3'b001, 32'hFFFFFFFD, 32'h00000007);
    check("mult_srca", mul_SrcA, 32'h00000003);
    check("mult_srcb", mul_SrcB, 32'h00000007);
    mf(3'b100, "mult_hi", 32'hFFFFFFFF);
    mf(3'b101, "mult_lo", 32'hFFFFFFEB);

    // MULT most-negative operands: 2^62
    send(3'b001, 32'h80000000, 32'h80000000);
    check("mneg_srca", mul_SrcA, 32'h80000000);
    mf(3'b100, "mneg_hi", 32'h40000000);
    mf(3'b101, "mneg_lo", 32'h00000000);

    // Stale done flag still high during ISSUE
    send(3'b000, 32'd2, 32'd3);
    check("stale_load", {31'd0, mul_validIn}, 32'd1);
    check("stale_ready_issue", {31'd0, op_ready}, 32'd0);
    @(negedge clk);
    check("stale_ready_wait", {31'd0, op_ready}, 32'd0);
    check("stale_load_wait", {31'd0, mul_validIn}, 32'd0);
    mf(3'b101, "stale_lo", 32'h00000006);
    mf(3'b100, "stale_hi", 32'h00000000);

    // Move-to / move-from back to back
    send(3'b010, 32'h12345678, '0);
    check("mt_ready0", {31'd0, op_ready}, 32'd1);
    send(3'b011, 32'h9ABCDEF0, '0);
    check("mt_ready1", {31'd0, op_ready}, 32'd1);
    mf(3'b100, "mv_hi", 32'h12345678);
    check("mt_ready2", {31'd0, op_ready}, 32'd1);
    mf(3'b101, "mv_lo", 32'h9ABCDEF0);
    check("mt_ready3", {31'd0, op_ready}, 32'd1);

    // Reset in WAIT, then the multiplier finishes late
    send(3'b000, 32'd5, 32'd7);
    @(negedge clk);
    check("rmid_busy_pre", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rmid_busy", {31'd0, busy}, 32'd0);
    check("rmid_ready", {31'd0, op_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("rmid_late_done", {31'd0, mul_validOut}, 32'd1);
    check("rmid_busy_after", {31'd0, busy}, 32'd0);
    check("rmid_ready_after", {31'd0, op_ready}, 32'd1);
    mf(3'b100, "rmid_hi", 32'h00000000);
    mf(3'b101, "rmid_lo", 32'h00000000);

    // Reserved op: accepted, HI/LO unchanged
    send(3'b110, 32'hDEADBEEF, 32'hDEADBEEF);
    check("rsv_busy", {31'd0, busy}, 32'd0);
    check("rsv_mf_vld", {31'd0, mf_valid}, 32'd0);

    // Zero operand, fast multiplier, signed: -0 must stay 0
    lat = 0;
    send(3'b010, 32'hAAAA5555, '0);
    send(3'b001, 32'h00000000, 32'hFFFFFFFB);
    mf(3'b100, "zero_hi", 32'h00000000);
    mf(3'b101, "zero_lo", 32'h00000000);

    // Negative times negative: -1 * -1 = 1
    send(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("nn_srca", mul_SrcA, 32'h00000001);
    mf(3'b100, "nn_hi", 32'h00000000);
    mf(3'b101, "nn_lo", 32'h00000001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
